// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  // Default oversample ratio of the shared baud tick and its mid-bit tick.
  localparam int unsigned DEF_OVERSAMPLE = 8;
  localparam int unsigned MID_TICK       = DEF_OVERSAMPLE / 2;
  localparam int unsigned MAX_DATA_BITS  = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // 2-of-3 vote over the mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit; zero padding above the data width does not alter the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers.
`timescale 1ns/1ps
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: rx synchroniser, majority-voted deframer and FWFT receive FIFO.
`timescale 1ns/1ps
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud8_tick,
  input  logic                 rx,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned TCW = $clog2(OVERSAMPLE);
  localparam int unsigned BIW = $clog2(DATA_BITS + 1);
  // Mid-bit tick scaled from the shared default ratio (OVERSAMPLE is even).
  localparam int unsigned MID = (MID_TICK * OVERSAMPLE) / DEF_OVERSAMPLE;
  localparam logic [TCW-1:0] TC_S0   = TCW'(MID - 1);
  localparam logic [TCW-1:0] TC_S1   = TCW'(MID);
  localparam logic [TCW-1:0] TC_RES  = TCW'(MID + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] IDX_END = BIW'(DATA_BITS);

  logic                 r_sync1, r_sync2;
  rx_state_t            r_state, w_state_nxt;
  logic [TCW-1:0]       r_tc, w_tc_nxt;
  logic [BIW-1:0]       r_bit_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_s0, w_s0_nxt, r_s1, w_s1_nxt;
  logic                 r_par_pend, w_par_nxt;
  logic                 r_frame_err, w_ferr_nxt;
  logic                 r_parity_err, w_perr_nxt;
  logic                 r_overrun, r_rx_busy;
  logic                 w_push, w_pop, w_full, w_empty;
  logic                 w_bit, w_resolve, w_wrap;

  assign w_bit     = majority3(r_s0, r_s1, r_sync2);
  assign w_resolve = baud8_tick && (r_tc == TC_RES);
  assign w_wrap    = baud8_tick && (r_tc == TC_LAST);
  assign w_pop     = rd_valid && rd_ready;

  // Two-flop synchroniser on the asynchronous rx line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Deframer next-state, datapath and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_tc_nxt    = r_tc;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_par_nxt   = r_par_pend;
    w_push      = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;

    if (baud8_tick && (r_state inside {START, DATA, PARITY, STOP})) begin
      w_tc_nxt = (r_tc == TC_LAST) ? '0 : r_tc + TCW'(1);
      if (r_tc == TC_S0) w_s0_nxt = r_sync2;
      if (r_tc == TC_S1) w_s1_nxt = r_sync2;
    end

    case (r_state)
      IDLE: begin
        if (baud8_tick && !r_sync2) begin
          w_state_nxt = START;
          w_tc_nxt    = '0;
          w_idx_nxt   = '0;
          w_par_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_resolve && w_bit) w_state_nxt = IDLE;
        else if (w_wrap)        w_state_nxt = DATA;
      end
      DATA: begin
        if (w_resolve) begin
          w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_bit_idx + BIW'(1);
        end
        if (w_wrap && (r_bit_idx == IDX_END))
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (w_resolve &&
            (w_bit != calc_parity(MAX_DATA_BITS'(r_shift), 1'(PARITY_ODD))))
          w_par_nxt = 1'b1;
        if (w_wrap) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_resolve) begin
          if (!w_bit) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end else begin
            w_perr_nxt  = r_par_pend;
            w_push      = !r_par_pend;
            w_state_nxt = IDLE;
          end
        end
      end
      BREAK: begin
        if (baud8_tick && r_sync2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tc         <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_par_pend   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_busy    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tc         <= w_tc_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_s0         <= w_s0_nxt;
      r_s1         <= w_s1_nxt;
      r_par_pend   <= w_par_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_parity_err <= w_perr_nxt;
      r_overrun    <= w_push && w_full && !w_pop;
      r_rx_busy    <= (w_state_nxt != IDLE);
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_shift_nxt),
    .o_rdata (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rd_valid   = !w_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign rx_busy    = r_rx_busy;

endmodule
